// File: rtl/turn_switch_conditioner_pkg.sv
// Shared constants for the turn-switch input stage: lockout FSM states and default timing.
package turn_switch_conditioner_pkg;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

    // State is one-hot in the output flops: bit 0 drives left_sw, bit 1 drives right_sw.
    localparam int unsigned ST_W     = 2;
    localparam logic [1:0]  ST_IDLE  = 2'b00;
    localparam logic [1:0]  ST_LEFT  = 2'b01;
    localparam logic [1:0]  ST_RIGHT = 2'b10;

    typedef struct packed {
        logic left;
        logic right;
    } sw_pair_t;

endpackage

// File: rtl/turn_switch_conditioner_switch_debouncer.sv
// One stalk channel: raw contact -> synchronizer chain -> consecutive-cycle debouncer.
module switch_debouncer
    import turn_switch_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic deb
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("switch_debouncer: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("switch_debouncer: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   deb_q, deb_d;
    logic                   syn;

    assign syn = sync_q[SYNC_STAGES-1];
    assign deb = deb_q;

    // A disagreeing sample advances the run; any agreeing sample restarts it.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw};
        cnt_d  = '0;
        deb_d  = deb_q;
        if (syn != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = syn;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

endmodule

// File: rtl/turn_switch_conditioner.sv
// Conditions raw left/right stalk contacts into mutually exclusive left_sw/right_sw levels.
module turn_switch_conditioner
    import turn_switch_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic left_raw,
    input  logic right_raw,
    output logic left_sw,
    output logic right_sw
);

    sw_pair_t        deb;
    logic [ST_W-1:0] state_q, state_d;

    switch_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_left (
        .clk  (clk),
        .reset(reset),
        .raw  (left_raw),
        .deb  (deb.left)
    );

    switch_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_right (
        .clk  (clk),
        .reset(reset),
        .raw  (right_raw),
        .deb  (deb.right)
    );

    // Lockout: a direction is held until its own switch releases; ambiguity stays idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (deb.left && !deb.right) begin
                    state_d = ST_LEFT;
                end else if (!deb.left && deb.right) begin
                    state_d = ST_RIGHT;
                end
            end
            ST_LEFT:  if (!deb.left)  state_d = ST_IDLE;
            ST_RIGHT: if (!deb.right) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign left_sw  = state_q[0];
    assign right_sw = state_q[1];

endmodule

// File: tb/tb_turn_switch_conditioner.sv
// Directed and randomized bench for turn_switch_conditioner against a history-window model.
module tb_turn_switch_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int MAXE = 8192;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic left_raw = 1'b0;
    logic right_raw = 1'b0;
    logic left_sw;
    logic right_sw;

    int n_pass = 0;
    int n_total = 0;

    // Model: per-edge record of what each channel's first sync flop captured and the
    // synchronized sample the debouncer saw; a channel flips once its last DEB samples
    // (all after the most recent reset) disagree with the current accepted level.
    bit cap  [2][MAXE];
    bit synu [2][MAXE];
    bit deb_m [2];
    int mstate = 0;
    int last_rst = -1;
    int k = 0;

    turn_switch_conditioner #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .left_raw (left_raw),
        .right_raw(right_raw),
        .left_sw  (left_sw),
        .right_sw (right_sw)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, k);
    endtask

    task automatic tick();
        bit raw [2];
        bit deb_old [2];
        bit flip;
        int idx;
        raw[0] = left_raw;
        raw[1] = right_raw;
        @(posedge clk);
        if (k >= MAXE) begin
            $display("FAIL model_overflow: edge %0d beyond %0d", k, MAXE);
            $fatal(1);
        end
        deb_old = deb_m;
        if (reset) begin
            last_rst = k;
            for (int c = 0; c < 2; c++) begin
                cap[c][k]  = 1'b0;
                synu[c][k] = 1'b0;
                deb_m[c]   = 1'b0;
            end
            mstate = 0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                cap[c][k]  = raw[c];
                synu[c][k] = (k - SYNC >= 0 && last_rst <= k - SYNC) ? cap[c][k-SYNC] : 1'b0;
                flip = 1'b1;
                for (int j = 0; j < DEB; j++) begin
                    idx = k - j;
                    if (idx < 0 || idx <= last_rst || synu[c][idx] == deb_m[c]) flip = 1'b0;
                end
                if (flip) deb_m[c] = ~deb_m[c];
            end
            case (mstate)
                0: begin
                    if (deb_old[0] && !deb_old[1]) mstate = 1;
                    else if (!deb_old[0] && deb_old[1]) mstate = 2;
                end
                1: if (!deb_old[0]) mstate = 0;
                default: if (!deb_old[1]) mstate = 0;
            endcase
        end
        k++;
        #1;
        check("model_left", left_sw, logic'(mstate == 1));
        check("model_right", right_sw, logic'(mstate == 2));
        check("exclusive", left_sw & right_sw, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // 1: reset with both switches held, then ambiguous request stays idle
        reset = 1'b1; left_raw = 1'b1; right_raw = 1'b1;
        tick();
        check("t1_rst_left", left_sw, 1'b0);
        check("t1_rst_right", right_sw, 1'b0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick();
            check("t1_both_left", left_sw, 1'b0);
            check("t1_both_right", right_sw, 1'b0);
        end

        // 2: left press, output from the 7th edge
        left_raw = 1'b0; right_raw = 1'b0;
        ticks(10);
        left_raw = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("t2_pre_left", left_sw, 1'b0);
        end
        tick();
        check("t2_left_on", left_sw, 1'b1);
        check("t2_right_off", right_sw, 1'b0);

        // 3: short pulse is filtered and the counter settles back to zero
        left_raw = 1'b0;
        ticks(10);
        left_raw = 1'b1;
        ticks(3);
        left_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("t3_no_left", left_sw, 1'b0);
        end
        check("t3_cnt_zero", logic'(dut.u_left.cnt_q == '0), 1'b1);

        // 4: lockout while left active, handover through idle
        left_raw = 1'b1;
        ticks(10);
        check("t4_left_on", left_sw, 1'b1);
        right_raw = 1'b1;
        ticks(10);
        check("t4_right_locked", right_sw, 1'b0);
        check("t4_left_held", left_sw, 1'b1);
        left_raw = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("t4_left_still", left_sw, 1'b1);
        end
        tick();
        check("t4_left_off7", left_sw, 1'b0);
        check("t4_right_off7", right_sw, 1'b0);
        tick();
        check("t4_right_on8", right_sw, 1'b1);

        // 5: simultaneous press rejected, then release of right grants left
        right_raw = 1'b0;
        ticks(10);
        left_raw = 1'b1; right_raw = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("t5_amb_left", left_sw, 1'b0);
            check("t5_amb_right", right_sw, 1'b0);
        end
        right_raw = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("t5_pre_left", left_sw, 1'b0);
        end
        tick();
        check("t5_left_on7", left_sw, 1'b1);

        // 6: release bounce while left active, then mid-operation reset
        left_raw = 1'b0;
        ticks(2);
        left_raw = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("t6_no_gap", left_sw, 1'b1);
        end
        reset = 1'b1;
        tick();
        check("t6_reset_left", left_sw, 1'b0);
        reset = 1'b0;

        // randomized contact activity with occasional resets
        for (int s = 0; s < 250; s++) begin
            reset = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 3) == 0) left_raw = ~left_raw;
            if ($urandom_range(0, 3) == 0) right_raw = ~right_raw;
            ticks(int'($urandom_range(1, 12)));
        end
        reset = 1'b0;
        ticks(12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
